// File: rtl/input_debouncer_4ch_pkg.sv
// Shared constants and types for the 4-channel input debouncer.
// Holds default timing, the short bench count and the a/b/c/d channel indices.
package input_debouncer_4ch_pkg;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_CNT_W       = 16;
  localparam int DEF_STABLE_CNT  = 50000;
  localparam int SIM_STABLE_CNT  = 4;

  localparam int NUM_CH = 4;
  localparam int CH_A   = 3;
  localparam int CH_B   = 2;
  localparam int CH_C   = 1;
  localparam int CH_D   = 0;

  typedef enum logic {
    WS_WARMUP = 1'b0,
    WS_RUN    = 1'b1
  } warm_state_e;

endpackage

// File: rtl/input_debouncer_4ch_if.sv
// Board-side bundle of the debouncer: raw switches in, clean levels and strobes out.
// The slave modport is the debouncer, the master modport is whoever drives the switches.
interface input_debouncer_4ch_if;
  import input_debouncer_4ch_pkg::*;

  // No handshake: raw_in is a free-running level, deb_out/ready are levels and
  // changed/rise/fall are single-cycle strobes with no backpressure.
  logic [NUM_CH-1:0] raw_in;
  logic [NUM_CH-1:0] deb_out;
  logic              ready;
  logic              changed;
  logic [NUM_CH-1:0] rise;
  logic [NUM_CH-1:0] fall;
  warm_state_e       state_dbg;

  modport master (
    output raw_in,
    input  deb_out, ready, changed, rise, fall, state_dbg
  );

  modport slave (
    input  raw_in,
    output deb_out, ready, changed, rise, fall, state_dbg
  );

endinterface

// File: rtl/input_debouncer_4ch_debounce_channel.sv
// One debounce lane: SYNC_STAGES-deep synchronizer, stability counter and level register.
// upd pulses combinationally on the cycle whose clock edge flips deb.
module debounce_channel
  import input_debouncer_4ch_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int STABLE_CNT  = DEF_STABLE_CNT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic deb,
  output logic upd
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CNT - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   deb_q, deb_d;
  logic                   sync_lvl;

  assign sync_lvl = sync_q[SYNC_STAGES-1];
  assign deb      = deb_q;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], raw};
    cnt_d  = cnt_q;
    deb_d  = deb_q;
    upd    = 1'b0;
    // Counter only advances while the synchronized level disagrees with deb,
    // so any bounce back to the old level restarts the qualification window.
    if (sync_lvl == deb_q) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      deb_d = sync_lvl;
      cnt_d = '0;
      upd   = 1'b1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      cnt_q  <= '0;
      deb_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      deb_q  <= deb_d;
    end
  end

endmodule

// File: rtl/input_debouncer_4ch.sv
// Four-channel switch/button debouncer feeding the a,b,c,d inputs of the gate-level labs.
// Define DEBOUNCE_EDGE_EN to build the per-channel rise/fall strobes; otherwise they read 0.
module input_debouncer_4ch
  import input_debouncer_4ch_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int STABLE_CNT  = DEF_STABLE_CNT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input_debouncer_4ch_if.slave  dbus
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CNT - 1);

  logic [NUM_CH-1:0] deb;
  logic [NUM_CH-1:0] upd;

  warm_state_e      state_q, state_d;
  logic [CNT_W-1:0] wcnt_q, wcnt_d;
  logic             ready_now, ready_next;
  logic             changed_q, changed_d;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    debounce_channel #(
      .SYNC_STAGES (SYNC_STAGES),
      .CNT_W       (CNT_W),
      .STABLE_CNT  (STABLE_CNT)
    ) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (dbus.raw_in[i]),
      .deb   (deb[i]),
      .upd   (upd[i])
    );
  end

  // Warm-up FSM: state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= WS_WARMUP;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Warm-up FSM: next state
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      WS_WARMUP: begin
        if (wcnt_q == LAST) state_d = WS_RUN;
        else                wcnt_d  = wcnt_q + CNT_W'(1);
      end
      WS_RUN:  state_d = WS_RUN;
      default: state_d = WS_WARMUP;
    endcase
  end

  // Warm-up FSM: outputs. Strobes are qualified with the next ready value so a
  // strobe can never be visible in a cycle where ready still reads 0.
  always_comb begin
    ready_now  = (state_q == WS_RUN);
    ready_next = (state_d == WS_RUN);
    changed_d  = ready_next & (|upd);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) changed_q <= 1'b0;
    else        changed_q <= changed_d;
  end

  assign dbus.deb_out   = deb;
  assign dbus.ready     = ready_now;
  assign dbus.changed   = changed_q;
  assign dbus.state_dbg = state_q;

`ifdef DEBOUNCE_EDGE_EN
  logic [NUM_CH-1:0] rise_q, rise_d, fall_q, fall_d;

  // upd means deb flips on this edge, so the current level tells the direction.
  always_comb begin
    rise_d = '0;
    fall_d = '0;
    if (ready_next) begin
      rise_d = upd & ~deb;
      fall_d = upd & deb;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign dbus.rise = rise_q;
  assign dbus.fall = fall_q;
`else
  assign dbus.rise = '0;
  assign dbus.fall = '0;
`endif

endmodule

// File: tb/tb_input_debouncer_4ch.sv
// Bench for input_debouncer_4ch with SYNC_STAGES=2, STABLE_CNT=4: directed scenarios
// plus randomized switch activity, all compared against a sample-history reference model.
module tb_input_debouncer_4ch;
  import input_debouncer_4ch_pkg::*;

  localparam int SYNC   = 2;
  localparam int STABLE = SIM_STABLE_CNT;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  input_debouncer_4ch_if dbus ();

  input_debouncer_4ch #(
    .SYNC_STAGES (SYNC),
    .CNT_W       (8),
    .STABLE_CNT  (STABLE)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .dbus  (dbus)
  );

  // ---------------- reference model ----------------
  // Output level flips once the synchronized input has disagreed with it on each
  // of the last STABLE edges, all of them after the previous flip / reset.
  logic [3:0] m_deb, m_rise, m_fall;
  logic       m_ready, m_changed;
  int         m_edges;
  int         m_since[4];
  logic [3:0] m_pipe[$];
  logic [3:0] m_hist[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input logic [3:0] r, input logic rn);
    logic [3:0] sy, flip, nd;
    logic       all_diff;
    if (!rn) begin
      m_deb = '0; m_rise = '0; m_fall = '0; m_changed = 1'b0; m_ready = 1'b0;
      m_edges = 0;
      m_pipe.delete();
      for (int k = 0; k < SYNC; k++) m_pipe.push_back(4'h0);
      m_hist.delete();
      for (int i = 0; i < 4; i++) m_since[i] = 0;
    end else begin
      sy = m_pipe.pop_front();
      m_pipe.push_back(r);
      m_hist.push_back(sy);
      if (m_hist.size() > STABLE) m_hist.delete(0);
      m_edges++;
      m_ready = (m_edges >= STABLE);
      flip = '0;
      for (int i = 0; i < 4; i++) begin
        m_since[i]++;
        if (m_since[i] >= STABLE) begin
          all_diff = 1'b1;
          foreach (m_hist[k]) if (m_hist[k][i] == m_deb[i]) all_diff = 1'b0;
          flip[i] = all_diff;
        end
        if (flip[i]) m_since[i] = 0;
      end
      nd = m_deb ^ flip;
      m_changed = m_ready && (flip != 4'h0);
`ifdef DEBOUNCE_EDGE_EN
      m_rise = m_ready ? (flip & nd)  : 4'h0;
      m_fall = m_ready ? (flip & ~nd) : 4'h0;
`else
      m_rise = 4'h0;
      m_fall = 4'h0;
`endif
      m_deb = nd;
    end
  endtask

  task automatic compare_all();
    check_eq("deb_out", dbus.deb_out, m_deb);
    check_eq("ready",   dbus.ready,   m_ready);
    check_eq("changed", dbus.changed, m_changed);
    check_eq("rise",    dbus.rise,    m_rise);
    check_eq("fall",    dbus.fall,    m_fall);
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input logic [3:0] r, input logic rn);
    dbus.raw_in = r;
    rst_n       = rn;
    @(posedge clk);
    model_edge(r, rn);
    #1;
    compare_all();
  endtask

  // Hold r for ncyc clocks; report first cycle deb_out==target (-1 if never),
  // number of changed pulses and OR of rise/fall seen.
  task automatic run_measure(input logic [3:0] r, input logic [3:0] target, input int ncyc,
                             output int lat, output int chg, output logic [3:0] rise_or,
                             output logic [3:0] fall_or, output int partial);
    lat = -1; chg = 0; rise_or = '0; fall_or = '0; partial = 0;
    for (int k = 1; k <= ncyc; k++) begin
      cycle(r, 1'b1);
      if (dbus.deb_out == target && lat < 0) lat = k;
      if (dbus.changed) chg++;
      rise_or |= dbus.rise;
      fall_or |= dbus.fall;
      if (dbus.deb_out != target && dbus.deb_out != 4'h0) partial++;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat, chg, partial;
    logic [3:0] rs, fl, raw;
    int hold[4];

    dbus.raw_in = 4'hF;
    rst_n = 1'b0;

    // Reset with all inputs high
    for (int k = 0; k < 3; k++) cycle(4'hF, 1'b0);
    check_eq("rst_deb",     dbus.deb_out, 4'h0);
    check_eq("rst_ready",   dbus.ready,   1'b0);
    check_eq("rst_changed", dbus.changed, 1'b0);

    // Warm-up: ready on the 4th clock after release
    for (int k = 0; k < 3; k++) cycle(4'h0, 1'b1);
    check_eq("ready_3rd", dbus.ready, 1'b0);
    cycle(4'h0, 1'b1);
    check_eq("ready_4th", dbus.ready, 1'b1);
    for (int k = 0; k < 4; k++) cycle(4'h0, 1'b1);

    // Clean step on channel a
    run_measure(4'b1000, 4'b1000, 12, lat, chg, rs, fl, partial);
    check_eq("step_lat", lat, 6);
    check_eq("step_chg", chg, 1);
`ifdef DEBOUNCE_EDGE_EN
    check_eq("step_rise", rs, 4'b1000);
`else
    check_eq("step_rise", rs, 4'b0000);
`endif
    check_eq("step_fall", fl, 4'b0000);

    // Glitch on channel d: 3 clocks high then back low
    for (int k = 0; k < 3; k++) cycle(4'b1001, 1'b1);
    run_measure(4'b1000, 4'b1000, 10, lat, chg, rs, fl, partial);
    check_eq("glitch_deb", dbus.deb_out, 4'b1000);
    check_eq("glitch_chg", chg, 0);

    // Return to zero, then simultaneous step on b and c
    run_measure(4'b0000, 4'b0000, 10, lat, chg, rs, fl, partial);
    check_eq("fall_chg", chg, 1);
`ifdef DEBOUNCE_EDGE_EN
    check_eq("fall_mask", fl, 4'b1000);
`else
    check_eq("fall_mask", fl, 4'b0000);
`endif
    run_measure(4'b0110, 4'b0110, 10, lat, chg, rs, fl, partial);
    check_eq("simul_lat",     lat, 6);
    check_eq("simul_chg",     chg, 1);
    check_eq("simul_partial", partial, 0);

    // Mid-operation reset while the channel a counter sits at 2
    run_measure(4'b0000, 4'b0000, 10, lat, chg, rs, fl, partial);
    for (int k = 0; k < 4; k++) cycle(4'b1000, 1'b1);
    cycle(4'b1000, 1'b0);
    check_eq("midrst_deb", dbus.deb_out, 4'h0);
    check_eq("midrst_chg", dbus.changed, 1'b0);
    run_measure(4'b1000, 4'b1000, 10, lat, chg, rs, fl, partial);
    check_eq("midrst_lat", lat, STABLE + 2);

    // Randomized switch activity with bouncy short holds and rare resets
    raw = 4'b1000;
    for (int i = 0; i < 4; i++) hold[i] = 0;
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < 4; i++) begin
        if (hold[i] == 0) begin
          raw[i]  = ~raw[i];
          hold[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(5, 12) : $urandom_range(1, 4);
        end else begin
          hold[i]--;
        end
      end
      cycle(raw, ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
